sa_conv_pe: RTL and testbench

- Parametrised, signed 1-D convolution processing element for the systolic array; successor to the fixed 3-tap PE.
- Holds TAPS stationary weights and slides a TAPS-deep input window over a streamed row.
- Adds an incoming partial sum from the upstream PE, so PEs can chain vertically for row-stationary accumulation.
- Uses valid/ready handshakes, a 2-stage stallable pipeline, a run FSM and optional saturation.

---
 rtl/sa_conv_pe_if.sv | 33 +++
 rtl/sa_conv_pe.sv | 137 +++++++++++++
 tb/tb_sa_conv_pe.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sa_conv_pe_if.sv
// Handshake and configuration bundle for one convolution PE: row control,
// weight stream, sample/psum stream and result stream.
interface sa_conv_pe_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 10
);
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_keep_w;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [ACC_W-1:0]  psum_in;
  logic              in_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_len, cfg_keep_w, w_valid, w_data, in_valid, in_data, psum_in, out_ready,
    input  w_ready, in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, cfg_len, cfg_keep_w, w_valid, w_data, in_valid, in_data, psum_in, out_ready,
    output w_ready, in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/sa_conv_pe.sv
// Signed TAPS-tap 1-D convolution PE: stationary weights, sliding input window,
// upstream psum add, 2-stage stallable result pipeline with optional saturation.
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_LOAD_W | shifting in TAPS weight beats
//   S_FILL   | priming the window with the first TAPS-1 samples
//   S_RUN    | every accepted sample issues one result
//   S_DRAIN  | waiting for the pipeline to empty, then done
module sa_conv_pe #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 3,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 10,
  parameter int SAT    = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  sa_conv_pe_if.slave pe
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + $clog2(TAPS + 1);
  localparam int CNT_W  = $clog2(TAPS);
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_FILL, S_RUN, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic signed [DATA_W-1:0] r_w   [TAPS];
  logic signed [DATA_W-1:0] r_win [TAPS-1];
  logic [CNT_W-1:0]         r_cnt;
  logic [LEN_W-1:0]         r_remain;
  logic                     r_s1_valid;
  logic signed [PROD_W-1:0] r_prod [TAPS];
  logic signed [ACC_W-1:0]  r_psum;
  logic                     r_out_valid;
  logic [ACC_W-1:0]         r_out_data;

  logic                     w_adv, w_start, w_w_acc, w_in_acc, w_drained;
  logic signed [DATA_W-1:0] w_x    [TAPS];
  logic signed [PROD_W-1:0] w_prod [TAPS];
  logic signed [SUM_W-1:0]  w_sum;
  logic [ACC_W-1:0]         w_res;

  assign w_adv     = !r_out_valid || pe.out_ready;
  assign w_start   = pe.start && (r_state == S_IDLE);
  assign w_w_acc   = pe.w_valid && (r_state == S_LOAD_W);
  assign w_in_acc  = pe.in_valid && pe.in_ready;
  assign w_drained = !r_s1_valid && !r_out_valid;

  assign pe.w_ready   = (r_state == S_LOAD_W);
  assign pe.in_ready  = ((r_state == S_FILL) || (r_state == S_RUN)) && w_adv;
  assign pe.out_valid = r_out_valid;
  assign pe.out_data  = r_out_data;
  assign pe.busy      = (r_state != S_IDLE);
  // done is decoded while still in DRAIN, so a start in the same cycle is ignored
  assign pe.done      = (r_state == S_DRAIN) && w_drained;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (pe.start) w_state_nxt = pe.cfg_keep_w ? S_FILL : S_LOAD_W;
      S_LOAD_W: if (w_w_acc && (r_cnt == '0)) w_state_nxt = S_FILL;
      S_FILL:   if (w_in_acc && (r_cnt == '0)) w_state_nxt = S_RUN;
      S_RUN:    if (w_in_acc && (r_remain == LEN_W'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_drained) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // weights shift in from the top so the first beat ends up in w[0]
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++)     r_w[k]   <= '0;
      for (int k = 0; k < TAPS - 1; k++) r_win[k] <= '0;
      r_cnt    <= '0;
      r_remain <= '0;
    end else begin
      if (w_start) begin
        for (int k = 0; k < TAPS - 1; k++) r_win[k] <= '0;
        r_cnt    <= pe.cfg_keep_w ? CNT_W'(TAPS - 2) : CNT_W'(TAPS - 1);
        r_remain <= pe.cfg_len;
      end
      if (w_w_acc) begin
        for (int k = 0; k < TAPS - 1; k++) r_w[k] <= r_w[k+1];
        r_w[TAPS-1] <= $signed(pe.w_data);
        r_cnt       <= (r_cnt == '0) ? CNT_W'(TAPS - 2) : r_cnt - 1'b1;
      end
      if (w_in_acc) begin
        for (int k = 0; k < TAPS - 2; k++) r_win[k] <= r_win[k+1];
        r_win[TAPS-2] <= $signed(pe.in_data);
        r_remain      <= r_remain - 1'b1;
        if (r_state == S_FILL) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS - 1; k++) w_x[k] = r_win[k];
    w_x[TAPS-1] = $signed(pe.in_data);
    for (int k = 0; k < TAPS; k++) w_prod[k] = PROD_W'(r_w[k]) * PROD_W'(w_x[k]);
  end

  // sum carries log2(TAPS+1) guard bits so saturation sees the true value
  always_comb begin
    w_sum = SUM_W'(r_psum);
    for (int k = 0; k < TAPS; k++) w_sum = w_sum + SUM_W'(r_prod[k]);
    w_res = w_sum[ACC_W-1:0];
    if (SAT != 0) begin
      if (w_sum > ACC_MAX)      w_res = ACC_MAX[ACC_W-1:0];
      else if (w_sum < ACC_MIN) w_res = ACC_MIN[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) r_prod[k] <= '0;
      r_psum      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_in_acc && (r_state == S_RUN);
      if (w_in_acc) begin
        for (int k = 0; k < TAPS; k++) r_prod[k] <= w_prod[k];
        r_psum <= $signed(pe.psum_in);
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_out_data <= w_res;
    end
  end
endmodule

// File: tb/tb_sa_conv_pe.sv
// Directed bench for sa_conv_pe: a wrap PE (ACC_W=24) plus two ACC_W=16 PEs
// (saturating and wrapping) driven with identical stimulus.
module tb_sa_conv_pe;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, cfg_keep_w = 1'b0, w_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [LW-1:0] cfg_len = '0;
  logic [7:0]    w_data = '0, in_data = '0;
  logic [23:0]   psum_in = '0;

  sa_conv_pe_if #(.DATA_W(8), .ACC_W(24), .LEN_W(LW)) ifm ();
  sa_conv_pe_if #(.DATA_W(8), .ACC_W(16), .LEN_W(LW)) ifs1 ();
  sa_conv_pe_if #(.DATA_W(8), .ACC_W(16), .LEN_W(LW)) ifs0 ();

  assign ifm.start = start, ifm.cfg_len = cfg_len, ifm.cfg_keep_w = cfg_keep_w,
         ifm.w_valid = w_valid, ifm.w_data = w_data, ifm.in_valid = in_valid,
         ifm.in_data = in_data, ifm.psum_in = psum_in, ifm.out_ready = out_ready;
  assign ifs1.start = start, ifs1.cfg_len = cfg_len, ifs1.cfg_keep_w = cfg_keep_w,
         ifs1.w_valid = w_valid, ifs1.w_data = w_data, ifs1.in_valid = in_valid,
         ifs1.in_data = in_data, ifs1.psum_in = psum_in[15:0], ifs1.out_ready = out_ready;
  assign ifs0.start = start, ifs0.cfg_len = cfg_len, ifs0.cfg_keep_w = cfg_keep_w,
         ifs0.w_valid = w_valid, ifs0.w_data = w_data, ifs0.in_valid = in_valid,
         ifs0.in_data = in_data, ifs0.psum_in = psum_in[15:0], ifs0.out_ready = out_ready;

  sa_conv_pe #(.DATA_W(8), .TAPS(3), .ACC_W(24), .LEN_W(LW), .SAT(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .pe(ifm));
  sa_conv_pe #(.DATA_W(8), .TAPS(3), .ACC_W(16), .LEN_W(LW), .SAT(1)) u_sat1 (
    .clk(clk), .reset_n(reset_n), .pe(ifs1));
  sa_conv_pe #(.DATA_W(8), .TAPS(3), .ACC_W(16), .LEN_W(LW), .SAT(0)) u_sat0 (
    .clk(clk), .reset_n(reset_n), .pe(ifs0));

  initial forever #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, cyc = 0;
  int got[$], got_s1[$], got_s0[$];
  int wv[$], sx[$], sp[$], ex[$];
  int n_acc, t_in3, t_out1, t_last, t_done, n_done, n_wready;
  int held, stall_bad, stall_t;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag);
    chk({tag, "_count"}, got.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : 32'h7fffffff, ex[i]);
  endtask

  task automatic clr_mon();
    got.delete(); got_s1.delete(); got_s0.delete();
    n_acc = 0; t_in3 = -1; t_out1 = -1; t_last = -1; t_done = -1; n_done = 0; n_wready = 0;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_start(input int len, input bit keep);
    cfg_len = LW'(len); cfg_keep_w = keep; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_w(input bit gappy);
    bit ok;
    for (int i = 0; i < wv.size(); i++) begin
      if (gappy) repeat ($urandom_range(0, 2)) begin w_valid = 1'b0; w_data = 8'($urandom); tick(); end
      w_valid = 1'b1; w_data = 8'(wv[i]); ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin @(negedge clk); ok = ifm.w_ready; tick(); end
      if (!ok) chk("w_timeout", 0, 1);
    end
    w_valid = 1'b0;
  endtask

  task automatic send_x(input bit gappy);
    bit ok;
    for (int i = 0; i < sx.size(); i++) begin
      if (gappy) repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; in_data = 8'($urandom); tick(); end
      in_valid = 1'b1; in_data = 8'(sx[i]); psum_in = 24'(sp[i]); ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin @(negedge clk); ok = ifm.in_ready; tick(); end
      if (!ok) chk("in_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 300 && n_done == 0; t++) tick();
    tick(); tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    fork
      forever begin @(posedge clk); cyc++; end
      forever begin
        @(negedge clk);
        if (in_valid && ifm.in_ready) begin n_acc++; if (n_acc == 3) t_in3 = cyc; end
        if (ifm.out_valid && t_out1 < 0) t_out1 = cyc;
        if (ifm.out_valid && out_ready) begin got.push_back(int'($signed(ifm.out_data))); t_last = cyc; end
        if (ifs1.out_valid && out_ready) got_s1.push_back(int'($signed(ifs1.out_data)));
        if (ifs0.out_valid && out_ready) got_s0.push_back(int'($signed(ifs0.out_data)));
        if (ifm.done) begin n_done++; t_done = cyc; end
        if (ifm.w_ready) n_wready++;
      end
    join_none
    clr_mon();

    // reset state
    repeat (3) @(posedge clk); #2;
    chk("rst_flags", int'({ifm.out_valid, ifm.busy, ifm.done, ifm.in_ready, ifm.w_ready}), 0);
    chk("rst_data", int'(ifm.out_data), 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_flags", int'({ifm.out_valid, ifm.busy, ifm.done, ifm.in_ready, ifm.w_ready}), 0);

    // row A: basic row, latency and done timing
    clr_mon();
    wv = '{1, 2, 3}; sx = '{1, 2, 3, 4, 5}; sp = '{0, 0, 0, 0, 0}; ex = '{14, 20, 26};
    do_start(5, 1'b0);
    chk("load_flags", int'({ifm.busy, ifm.w_ready, ifm.in_ready}), 6);
    send_w(1'b0); send_x(1'b0); wait_done();
    chk_q("rowA");
    chk("first_latency", t_out1 - t_in3, 2);
    chk("done_latency", t_done - t_last, 1);
    chk("rowA_done_cnt", n_done, 1);
    chk("rowA_idle", int'(ifm.busy), 0);

    // row B: upstream psum on window-completing beats only
    clr_mon();
    sp = '{999, -999, 100, -20, 7}; ex = '{114, 0, 33};
    do_start(5, 1'b0);
    send_w(1'b0); send_x(1'b0); wait_done();
    chk_q("rowB");

    // row C: keep weights, no weight load
    clr_mon();
    sx = '{-1, 0, 1}; sp = '{0, 0, 0}; ex = '{2};
    do_start(3, 1'b1);
    send_x(1'b0); wait_done();
    chk_q("rowC");
    chk("rowC_no_w_ready", n_wready, 0);
    chk("rowC_done_cnt", n_done, 1);

    // row D: 4-cycle output stall mid-row
    clr_mon();
    sx = '{1, 2, 3, 4, 5, 6}; sp = '{0, 0, 0, 0, 0, 0}; ex = '{14, 20, 26, 32};
    stall_bad = 0; stall_t = 0;
    do_start(6, 1'b1);
    fork
      send_x(1'b0);
      begin
        while (!ifm.out_valid && stall_t < 100) begin @(negedge clk); stall_t++; end
        @(posedge clk); #1; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 0) held = int'(ifm.out_data);
          if (ifm.in_ready || !ifm.out_valid || (int'(ifm.out_data) != held)) stall_bad++;
        end
        @(posedge clk); #1; out_ready = 1'b1;
      end
    join
    wait_done();
    chk("stall_reached", int'(stall_t < 100), 1);
    chk("stall_hold", stall_bad, 0);
    chk_q("rowD");

    // row E: -128 everywhere, wrap vs saturate
    clr_mon();
    wv = '{-128, -128, -128}; sx = '{-128, -128, -128}; sp = '{0, 0, 0}; ex = '{49152};
    do_start(3, 1'b0);
    send_w(1'b0); send_x(1'b0); wait_done();
    chk_q("rowE_acc24");
    chk("sat1_count", got_s1.size(), 1);
    chk("sat1_value", (got_s1.size() > 0) ? got_s1[0] : 32'h7fffffff, 32767);
    chk("sat0_value", (got_s0.size() > 0) ? got_s0[0] : 32'h7fffffff, -16384);

    // row F: bubbles on both streams, random backpressure, start while busy
    clr_mon();
    wv = '{1, 2, 3}; sx = '{1, 2, 3, 4, 5}; sp = '{0, 0, 0, 0, 0}; ex = '{14, 20, 26};
    do_start(5, 1'b0);
    do_start(3, 1'b1);
    chk("start_busy_ignored", int'({ifm.busy, ifm.w_ready}), 3);
    fork
      begin send_w(1'b1); send_x(1'b1); wait_done(); end
      begin
        for (int t = 0; t < 400 && n_done == 0; t++) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1'b1;
      end
    join
    chk_q("rowF");
    chk("rowF_done_cnt", n_done, 1);

    // row G: reset in RUN, then zero weights pass psum through
    clr_mon();
    sx = '{1, 2, 3, 4}; sp = '{0, 0, 0, 0};
    do_start(8, 1'b0);
    send_w(1'b0); send_x(1'b0);
    chk("pre_rst_run", int'({ifm.busy, ifm.out_valid}), 3);
    in_valid = 1'b1; #1;
    reset_n = 1'b0; #1;
    chk("mid_rst_flags", int'({ifm.out_valid, ifm.busy, ifm.done, ifm.in_ready, ifm.w_ready}), 0);
    tick(); tick();
    in_valid = 1'b0; reset_n = 1'b1;
    tick(); tick();
    chk("abort_no_done", n_done, 0);
    clr_mon();
    sx = '{5, 6, 7, 8}; sp = '{50, 60, 11, -33}; ex = '{11, -33};
    do_start(4, 1'b1);
    send_x(1'b0); wait_done();
    chk_q("rowG_zero_w");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
